// File: rtl/revelar_ctrl.sv
// Reveal sequencer for the 8x8 mine board: checks one request against the bomb map and sweeps to flood-reveal zero regions.
// Optional build macro REVELAR_BANDERA_EN: flagged cells are protected from request and sweep reveals.
module revelar_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        limpiar,
  input  logic        revelar,
  input  logic [2:0]  fila,
  input  logic [2:0]  col,
  input  logic [63:0] bombas,
  input  logic [63:0] banderas,
  input  logic [2:0]  rd_fila,
  input  logic [2:0]  rd_col,
  output logic [3:0]  rd_conteo,
  output logic        rd_revelada,
  output logic [63:0] reveladas,
  output logic [6:0]  cantidad_reveladas,
  output logic        ocupado,
  output logic        listo,
  output logic        pierde,
  output logic        gana
);

  localparam int unsigned N_CELLS = 64;
  localparam int unsigned SIDE    = 8;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned CANT_W  = 7;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SWEEP = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Mines among the in-board neighbours of (r,c); rows do not wrap into each other.
  function automatic logic [CNT_W-1:0] mine_count(input logic [N_CELLS-1:0] m, input int r, input int c);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0) && (r + dr) >= 0 && (r + dr) < int'(SIDE) &&
            (c + dc) >= 0 && (c + dc) < int'(SIDE)) begin
          if (m[IDX_W'((r + dr) * int'(SIDE) + c + dc)]) n = n + CNT_W'(1);
        end
      end
    end
    return n;
  endfunction

  function automatic logic any_neighbour(input logic [N_CELLS-1:0] m, input int r, input int c);
    logic hit;
    hit = 1'b0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0) && (r + dr) >= 0 && (r + dr) < int'(SIDE) &&
            (c + dc) >= 0 && (c + dc) < int'(SIDE)) begin
          if (m[IDX_W'((r + dr) * int'(SIDE) + c + dc)]) hit = 1'b1;
        end
      end
    end
    return hit;
  endfunction

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cell_q, cell_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                change_q, change_d;
  logic [N_CELLS-1:0]  reveladas_q, reveladas_d;
  logic [CANT_W-1:0]   cantidad_q, cantidad_d;
  logic                pierde_q, pierde_d;
  logic                gana_q, gana_d;
  logic                listo_q, listo_d;
  logic                ocupado_q, ocupado_d;

  logic [CNT_W-1:0]    conteo [N_CELLS];
  logic [N_CELLS-1:0]  cero_map;
  logic [CANT_W-1:0]   n_bombas;
  logic                flag_cell;
  logic                flag_idx;
  logic                req_ok;
  logic                chk_skip;
  logic                chk_mine;
  logic                chk_zero;
  logic                swp_hit;
  logic                swp_last;

  // Per-cell neighbour counts, zero-count map and total mine count.
  always_comb begin
    n_bombas = '0;
    for (int i = 0; i < int'(N_CELLS); i++) begin
      conteo[IDX_W'(i)]   = mine_count(bombas, i / int'(SIDE), i % int'(SIDE));
      cero_map[IDX_W'(i)] = (conteo[IDX_W'(i)] == '0);
      n_bombas            = n_bombas + CANT_W'(bombas[IDX_W'(i)]);
    end
  end

`ifdef REVELAR_BANDERA_EN
  assign flag_cell = banderas[cell_q];
  assign flag_idx  = banderas[idx_q];
`else
  logic unused_banderas;
  assign unused_banderas = ^banderas;
  assign flag_cell       = 1'b0;
  assign flag_idx        = 1'b0;
`endif

  assign req_ok   = revelar && !pierde_q && !gana_q;
  assign chk_skip = flag_cell || reveladas_q[cell_q];
  assign chk_mine = bombas[cell_q];
  assign chk_zero = cero_map[cell_q];
  // Sweep sees the registered bitmap, so a reveal at index i is visible to index i+1.
  assign swp_hit  = !reveladas_q[idx_q] && !bombas[idx_q] && !flag_idx &&
                    any_neighbour(reveladas_q & cero_map, int'(idx_q[5:3]), int'(idx_q[2:0]));
  assign swp_last = (idx_q == IDX_W'(N_CELLS - 1));

  always_ff @(posedge clk) begin
    if (rst || limpiar) begin
      state_q     <= IDLE;
      cell_q      <= '0;
      idx_q       <= '0;
      change_q    <= 1'b0;
      reveladas_q <= '0;
      cantidad_q  <= '0;
      pierde_q    <= 1'b0;
      gana_q      <= 1'b0;
      listo_q     <= 1'b0;
      ocupado_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cell_q      <= cell_d;
      idx_q       <= idx_d;
      change_q    <= change_d;
      reveladas_q <= reveladas_d;
      cantidad_q  <= cantidad_d;
      pierde_q    <= pierde_d;
      gana_q      <= gana_d;
      listo_q     <= listo_d;
      ocupado_q   <= ocupado_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (req_ok) state_d = CHECK;
      CHECK: begin
        if (chk_skip || chk_mine || !chk_zero) state_d = DONE;
        else                                   state_d = SWEEP;
      end
      SWEEP: if (swp_last && !(change_q || swp_hit)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_comb begin
    cell_d      = cell_q;
    idx_d       = idx_q;
    change_d    = change_q;
    reveladas_d = reveladas_q;
    cantidad_d  = cantidad_q;
    pierde_d    = pierde_q;
    gana_d      = gana_q;
    listo_d     = (state_d == DONE);
    ocupado_d   = (state_d != IDLE);
    unique case (state_q)
      IDLE: if (req_ok) cell_d = {fila, col};
      CHECK: begin
        if (!chk_skip) begin
          reveladas_d[cell_q] = 1'b1;
          cantidad_d          = cantidad_q + CANT_W'(1);
          if (chk_mine) begin
            pierde_d = 1'b1;
          end else if (chk_zero) begin
            idx_d    = '0;
            change_d = 1'b0;
          end
        end
      end
      SWEEP: begin
        if (swp_hit) begin
          reveladas_d[idx_q] = 1'b1;
          cantidad_d         = cantidad_q + CANT_W'(1);
          change_d           = 1'b1;
        end
        if (swp_last) begin
          idx_d    = '0;
          change_d = 1'b0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (!pierde_q && cantidad_q == CANT_W'(N_CELLS) - n_bombas) gana_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign rd_conteo          = conteo[{rd_fila, rd_col}];
  assign rd_revelada        = reveladas_q[{rd_fila, rd_col}];
  assign reveladas          = reveladas_q;
  assign cantidad_reveladas = cantidad_q;
  assign ocupado            = ocupado_q;
  assign listo              = listo_q;
  assign pierde             = pierde_q;
  assign gana               = gana_q;

endmodule

// File: tb/tb_revelar_ctrl.sv
// Directed bench for revelar_ctrl: latency, cascade, loss/win, no-wrap counts, dropped requests and mid-sweep clear.
module tb_revelar_ctrl;

  logic        clk = 1'b0;
  logic        rst, limpiar, revelar;
  logic [2:0]  fila, col, rd_fila, rd_col;
  logic [63:0] bombas, banderas;
  logic [3:0]  rd_conteo;
  logic        rd_revelada;
  logic [63:0] reveladas;
  logic [6:0]  cantidad_reveladas;
  logic        ocupado, listo, pierde, gana;

  int n_checks = 0;
  int n_fail   = 0;
  int n_listo  = 0;
  int lat;
  int listo_ref;

  revelar_ctrl dut (
    .clk(clk), .rst(rst), .limpiar(limpiar), .revelar(revelar),
    .fila(fila), .col(col), .bombas(bombas), .banderas(banderas),
    .rd_fila(rd_fila), .rd_col(rd_col), .rd_conteo(rd_conteo), .rd_revelada(rd_revelada),
    .reveladas(reveladas), .cantidad_reveladas(cantidad_reveladas),
    .ocupado(ocupado), .listo(listo), .pierde(pierde), .gana(gana)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (listo) n_listo++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Request sampled at the returned edge N.
  task automatic start_reveal(input logic [2:0] r, input logic [2:0] c);
    @(negedge clk);
    fila = r; col = c; revelar = 1'b1;
    @(posedge clk);
    #1 revelar = 1'b0;
  endtask

  // Returns the cycle index (relative to N) in which listo is high, or -1 on timeout.
  task automatic wait_listo(output int l);
    l = -1;
    for (int k = 1; k <= 5000; k++) begin
      @(posedge clk);
      #1;
      if (listo) begin
        l = k + 1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic read_cell(input logic [2:0] r, input logic [2:0] c);
    rd_fila = r; rd_col = c;
    #1;
  endtask

  initial begin
    rst = 1'b0; limpiar = 1'b0; revelar = 1'b0;
    fila = '0; col = '0; rd_fila = '0; rd_col = '0;
    bombas = '0; banderas = '0;

    do_reset();
    check_eq("rst_reveladas", reveladas, 64'h0);
    check_eq("rst_cantidad", 64'(cantidad_reveladas), 64'd0);
    check_eq("rst_ocupado", 64'(ocupado), 64'd0);
    check_eq("rst_listo", 64'(listo), 64'd0);
    check_eq("rst_pierde", 64'(pierde), 64'd0);
    check_eq("rst_gana", 64'(gana), 64'd0);

    // Empty board: full cascade, two passes.
    start_reveal(3'd0, 3'd0);
    check_eq("empty_ocupado_rise", 64'(ocupado), 64'd1);
    wait_listo(lat);
    check_eq("empty_latency", 64'(lat), 64'd130);
    check_eq("empty_bitmap", reveladas, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("empty_cantidad", 64'(cantidad_reveladas), 64'd64);
    check_eq("empty_gana", 64'(gana), 64'd1);
    check_eq("empty_idle", 64'(ocupado), 64'd0);
    start_reveal(3'd1, 3'd1);
    check_eq("won_req_ignored", 64'(ocupado), 64'd0);

    // Single mine at (0,1): non-cascading reveal, then loss.
    bombas = 64'h2;
    do_reset();
    start_reveal(3'd0, 3'd0);
    wait_listo(lat);
    check_eq("m01_latency", 64'(lat), 64'd2);
    check_eq("m01_bitmap", reveladas, 64'h1);
    check_eq("m01_cantidad", 64'(cantidad_reveladas), 64'd1);
    check_eq("m01_gana", 64'(gana), 64'd0);
    read_cell(3'd0, 3'd0);
    check_eq("m01_conteo00", 64'(rd_conteo), 64'd1);
    check_eq("m01_rdrev00", 64'(rd_revelada), 64'd1);
    start_reveal(3'd0, 3'd1);
    wait_listo(lat);
    check_eq("lose_latency", 64'(lat), 64'd2);
    check_eq("lose_pierde", 64'(pierde), 64'd1);
    check_eq("lose_bitmap", reveladas, 64'h3);
    listo_ref = n_listo;
    start_reveal(3'd5, 3'd5);
    check_eq("lost_req_ocupado", 64'(ocupado), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("lost_req_bitmap", reveladas, 64'h3);
    check_eq("lost_req_listo", 64'(n_listo), 64'(listo_ref));

    // Row 3 all mines: flood stops at row 2.
    bombas = 64'h0000_0000_FF00_0000;
    do_reset();
    start_reveal(3'd0, 3'd0);
    wait_listo(lat);
    check_eq("row3_latency", 64'(lat), 64'd130);
    check_eq("row3_bitmap", reveladas, 64'h0000_0000_00FF_FFFF);
    check_eq("row3_cantidad", 64'(cantidad_reveladas), 64'd24);
    check_eq("row3_pierde", 64'(pierde), 64'd0);
    read_cell(3'd2, 3'd4);
    check_eq("row3_conteo24", 64'(rd_conteo), 64'd3);
    read_cell(3'd2, 3'd0);
    check_eq("row3_conteo20", 64'(rd_conteo), 64'd2);
    read_cell(3'd4, 3'd0);
    check_eq("row3_conteo40", 64'(rd_conteo), 64'd2);
    read_cell(3'd3, 3'd3);
    check_eq("row3_rdrev33", 64'(rd_revelada), 64'd0);

    // No wrap: a mine at (0,7) is not adjacent to (1,0).
    bombas = 64'h80;
    read_cell(3'd1, 3'd0);
    check_eq("nowrap_conteo10", 64'(rd_conteo), 64'd0);
    read_cell(3'd1, 3'd6);
    check_eq("nowrap_conteo16", 64'(rd_conteo), 64'd1);
    read_cell(3'd0, 3'd0);
    check_eq("nowrap_conteo00", 64'(rd_conteo), 64'd0);

    // Flag at (7,7) on an empty board.
    bombas = '0;
    banderas = 64'h8000_0000_0000_0000;
    do_reset();
    start_reveal(3'd0, 3'd0);
    wait_listo(lat);
    check_eq("flag_latency", 64'(lat), 64'd130);
`ifdef REVELAR_BANDERA_EN
    check_eq("flag_bitmap", reveladas, 64'h7FFF_FFFF_FFFF_FFFF);
    check_eq("flag_cantidad", 64'(cantidad_reveladas), 64'd63);
    check_eq("flag_gana", 64'(gana), 64'd0);
`else
    check_eq("flag_bitmap", reveladas, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("flag_cantidad", 64'(cantidad_reveladas), 64'd64);
    check_eq("flag_gana", 64'(gana), 64'd1);
`endif
    banderas = '0;

    // Request onto a mine while sweeping is dropped.
    bombas = 64'h0000_0000_FF00_0000;
    do_reset();
    listo_ref = n_listo;
    start_reveal(3'd0, 3'd0);
    repeat (10) @(posedge clk);
    start_reveal(3'd3, 3'd3);
    check_eq("drop_busy", 64'(ocupado), 64'd1);
    repeat (200) @(posedge clk);
    #1;
    check_eq("drop_listo_count", 64'(n_listo), 64'(listo_ref + 1));
    check_eq("drop_pierde", 64'(pierde), 64'd0);
    check_eq("drop_bitmap", reveladas, 64'h0000_0000_00FF_FFFF);

    // limpiar in the middle of a sweep.
    bombas = '0;
    do_reset();
    listo_ref = n_listo;
    start_reveal(3'd0, 3'd0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    limpiar = 1'b1;
    @(posedge clk);
    #1;
    check_eq("clr_ocupado", 64'(ocupado), 64'd0);
    check_eq("clr_bitmap", reveladas, 64'h0);
    check_eq("clr_cantidad", 64'(cantidad_reveladas), 64'd0);
    check_eq("clr_listo", 64'(listo), 64'd0);
    @(negedge clk);
    limpiar = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    check_eq("clr_no_listo", 64'(n_listo), 64'(listo_ref));
    check_eq("clr_stays_idle", 64'(ocupado), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
